// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the PWM capture slice: the default counter width and
// the capture state machine encoding used by pwm_capture.
package pwm_pkg;

  // Default bit width of CYCLE, DUTY and PHASE
  localparam int PWM_WIDTH_DEFAULT = 13;

  // Capture FSM states
  //   IDLE : no valid period loaded, nothing measured
  //   ARM  : period just loaded, waiting for the counter to sit at t==0
  //   MEAS : measuring one period after another
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter
// Holds the PWM period and the free-running position counter t inside it.
//
// Ports
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_set    : load i_cycle as the new period and restart t at 0
//   i_cycle  : period in clocks
//   o_period : currently loaded period
//   o_t      : position inside the period, 0 .. period-1
//   o_wrap   : high while t sits at period-1 (last clock of the period)
module pwm_period_counter #(
  parameter int WIDTH = 13
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_set,
  input  logic [WIDTH-1:0] i_cycle,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_t,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_t;
  logic             w_wrap;

  // A zero period never wraps, so t simply parks at 0 until a real period
  // is loaded.
  assign w_wrap = (r_period != '0) && (r_t == r_period - WIDTH'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_period <= '0;
      r_t      <= '0;
    end else if (i_set) begin
      r_period <= i_cycle;
      r_t      <= '0;
    end else if (r_period != '0) begin
      r_t <= w_wrap ? '0 : r_t + WIDTH'(1);
    end
  end

  assign o_period = r_period;
  assign o_t      = r_t;
  assign o_wrap   = w_wrap;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
// Measures high time (DUTY) and first rising-edge position (PHASE) of a PWM
// waveform over each period of a programmable length, publishing a result
// with a one-clock VALID strobe at the end of every measured period.
//
// Ports
//   CLK    : clock, rising edge
//   RST    : asynchronous active-high reset
//   SET    : load CYCLE as the new period and restart measurement
//   CYCLE  : period in clocks
//   PWM_IN : waveform under measurement, synchronous to CLK
//   DUTY   : measured high time of the last published period
//   PHASE  : measured rising-edge position of the last published period
//   VALID  : one-clock strobe marking a new DUTY/PHASE
//   ERR    : sticky flag, a second rising edge was seen within one period
//
// Build option
//   PWM_CAPTURE_PHASE_INV_EN : when defined, PHASE is reported as
//   (period - rise_t) mod period instead of rise_t.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SET,
  input  logic [WIDTH-1:0] CYCLE,
  input  logic             PWM_IN,
  output logic [WIDTH-1:0] DUTY,
  output logic [WIDTH-1:0] PHASE,
  output logic             VALID,
  output logic             ERR
);

  logic [WIDTH-1:0] w_period;
  logic [WIDTH-1:0] w_t;
  logic             w_wrap;

  pwm_state_t       r_state;
  pwm_state_t       w_state_next;

  logic             r_prev;
  logic             r_seen;
  logic             r_valid;
  logic             r_err;
  logic [WIDTH-1:0] r_high;
  logic [WIDTH-1:0] r_rise_t;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_phase;

  logic             w_meas;
  logic             w_rise;
  logic             w_seen_next;
  logic [WIDTH-1:0] w_high_next;
  logic [WIDTH-1:0] w_rise_t_next;
  logic [WIDTH-1:0] w_phase_pub;

  pwm_period_counter #(
    .WIDTH (WIDTH)
  ) u_period_counter (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_set    (SET),
    .i_cycle  (CYCLE),
    .o_period (w_period),
    .o_t      (w_t),
    .o_wrap   (w_wrap)
  );

  // ARM only ever lasts the single t==0 clock after a SET; that sample
  // already belongs to the first measured period, so it is counted here.
  always_comb begin
    w_meas        = (r_state == MEAS) || ((r_state == ARM) && (w_t == '0));
    w_rise        = w_meas && !r_prev && PWM_IN;
    w_high_next   = r_high;
    if (PWM_IN && (r_high < w_period)) begin
      w_high_next = r_high + WIDTH'(1);
    end
    w_seen_next   = r_seen | w_rise;
    w_rise_t_next = (w_rise && !r_seen) ? w_t : r_rise_t;
  end

  // Value published as PHASE, including a rise on the final sample.
  always_comb begin
    w_phase_pub = '0;
`ifdef PWM_CAPTURE_PHASE_INV_EN
    if (w_seen_next && (w_rise_t_next != '0)) begin
      w_phase_pub = w_period - w_rise_t_next;
    end
`else
    if (w_seen_next) begin
      w_phase_pub = w_rise_t_next;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // SET overrides everything, including an abort of a running period.
  always_comb begin
    w_state_next = r_state;
    if (SET) begin
      w_state_next = (CYCLE >= WIDTH'(2)) ? ARM : IDLE;
    end else begin
      case (r_state)
        ARM:     if (w_t == '0) w_state_next = MEAS;
        MEAS:    w_state_next = MEAS;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Measurement datapath. SET wins over a simultaneous period-end publish,
  // and the previous-sample register runs continuously so edges that
  // straddle a period wrap are still seen.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prev   <= 1'b0;
      r_seen   <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_high   <= '0;
      r_rise_t <= '0;
      r_duty   <= '0;
      r_phase  <= '0;
    end else begin
      r_prev  <= PWM_IN;
      r_valid <= 1'b0;
      if (SET) begin
        r_seen   <= 1'b0;
        r_err    <= 1'b0;
        r_high   <= '0;
        r_rise_t <= '0;
      end else if (w_meas) begin
        if (w_rise && r_seen) begin
          r_err <= 1'b1;
        end
        if (w_wrap) begin
          r_duty   <= w_high_next;
          r_phase  <= w_phase_pub;
          r_valid  <= 1'b1;
          r_seen   <= 1'b0;
          r_high   <= '0;
          r_rise_t <= '0;
        end else begin
          r_seen   <= w_seen_next;
          r_high   <= w_high_next;
          r_rise_t <= w_rise_t_next;
        end
      end
    end
  end

  assign DUTY  = r_duty;
  assign PHASE = r_phase;
  assign VALID = r_valid;
  assign ERR   = r_err;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Directed bench for pwm_capture: a table of waveform vectors (period, high
// windows, expected DUTY / rise position / ERR) plus hand-written sequences
// for SET-at-period-end, SET abort, mid-period reset and too-short periods.
module tb_pwm_capture;

  localparam int W = 13;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         SET = 1'b0;
  logic [W-1:0] CYCLE = '0;
  logic         PWM_IN = 1'b0;
  logic [W-1:0] DUTY;
  logic [W-1:0] PHASE;
  logic         VALID;
  logic         ERR;

  int testsRun = 0;
  int testsFailed = 0;

  pwm_capture #(
    .WIDTH (W)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SET    (SET),
    .CYCLE  (CYCLE),
    .PWM_IN (PWM_IN),
    .DUTY   (DUTY),
    .PHASE  (PHASE),
    .VALID  (VALID),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  // A vector drives PWM_IN high for t in [lo1,hi1] and [lo2,hi2] (empty when
  // hi < lo) and lists the result expected at every period end.
  typedef struct {
    int cycle;
    int lo1;
    int hi1;
    int lo2;
    int hi2;
    int expDuty;
    int expRise;
    int expErr;
  } vec_t;

  vec_t vecs[5];

  function automatic int expPhase(int cyc, int rise);
`ifdef PWM_CAPTURE_PHASE_INV_EN
    return (rise == 0) ? 0 : cyc - rise;
`else
    return rise + 0 * cyc;
`endif
  endfunction

  function automatic logic pwmAt(vec_t v, int t);
    return ((t >= v.lo1) && (t <= v.hi1)) || ((t >= v.lo2) && (t <= v.hi2));
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic doSet(int cyc);
    CYCLE = W'(cyc);
    SET   = 1'b1;
    @(posedge CLK);
    #1;
    SET   = 1'b0;
  endtask

  // Runs nPeriods periods of a vector right after its SET, expecting VALID
  // exactly on each period end and the vector's result at every VALID.
  task automatic applyStimulus(vec_t v, int nPeriods, string tag);
    int valids = 0;
    int badTiming = 0;
    for (int cyc = 0; cyc < nPeriods * v.cycle; cyc++) begin
      PWM_IN = pwmAt(v, cyc % v.cycle);
      @(posedge CLK);
      #1;
      if (VALID !== ((cyc % v.cycle) == v.cycle - 1)) badTiming++;
      if (VALID === 1'b1) begin
        valids++;
        checkOutput({tag, " duty"}, 32'(DUTY), v.expDuty);
        checkOutput({tag, " phase"}, 32'(PHASE), expPhase(v.cycle, v.expRise));
        checkOutput({tag, " err"}, 32'(ERR), v.expErr);
      end
    end
    checkOutput({tag, " valid count"}, valids, nPeriods);
    checkOutput({tag, " valid timing errors"}, badTiming, 0);
  endtask

  // Free-running cycles with a given high window, no checks.
  task automatic runCycles(int n, int cyc, int hi);
    for (int i = 0; i < n; i++) begin
      PWM_IN = ((i % cyc) <= hi);
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    vec_t vA;
    vec_t vB;
    vec_t vC;
    int   valids;

    vecs[0] = '{cycle: 5000, lo1: 0,    hi1: 2499, lo2: 1, hi2: 0,  expDuty: 2500, expRise: 0,    expErr: 0};
    vecs[1] = '{cycle: 5000, lo1: 1000, hi1: 1799, lo2: 1, hi2: 0,  expDuty: 800,  expRise: 1000, expErr: 0};
    vecs[2] = '{cycle: 100,  lo1: 0,    hi1: 99,   lo2: 1, hi2: 0,  expDuty: 100,  expRise: 0,    expErr: 0};
    vecs[3] = '{cycle: 100,  lo1: 10,   hi1: 19,   lo2: 40, hi2: 44, expDuty: 15,  expRise: 10,   expErr: 1};
    vecs[4] = '{cycle: 100,  lo1: 1,    hi1: 0,    lo2: 1, hi2: 0,  expDuty: 0,    expRise: 0,    expErr: 0};

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset duty", 32'(DUTY), 0);
    checkOutput("reset phase", 32'(PHASE), 0);
    checkOutput("reset valid", 32'(VALID), 0);
    checkOutput("reset err", 32'(ERR), 0);
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Table-driven vectors, two periods each
    for (int i = 0; i < 5; i++) begin
      doSet(vecs[i].cycle);
      checkOutput($sformatf("vec%0d valid after set", i), 32'(VALID), 0);
      if (i == 4) checkOutput("err cleared by set", 32'(ERR), 0);
      applyStimulus(vecs[i], 2, $sformatf("vec%0d", i));
    end

    // SET on the very clock a period would publish: no VALID, DUTY held
    vA = '{cycle: 100, lo1: 0, hi1: 29, lo2: 1, hi2: 0, expDuty: 30, expRise: 0, expErr: 0};
    doSet(100);
    applyStimulus(vA, 1, "preset");
    runCycles(99, 100, 49);
    PWM_IN = 1'b0;
    doSet(100);
    checkOutput("set at period end valid", 32'(VALID), 0);
    checkOutput("set at period end duty held", 32'(DUTY), 30);
    vB = '{cycle: 100, lo1: 0, hi1: 9, lo2: 1, hi2: 0, expDuty: 10, expRise: 0, expErr: 0};
    applyStimulus(vB, 1, "rearm");

    // SET CYCLE=200 at t=50 of a CYCLE=100 measurement
    runCycles(50, 100, 19);
    PWM_IN = 1'b0;
    doSet(200);
    checkOutput("abort valid", 32'(VALID), 0);
    checkOutput("abort duty held", 32'(DUTY), 10);
    vC = '{cycle: 200, lo1: 0, hi1: 59, lo2: 1, hi2: 0, expDuty: 60, expRise: 0, expErr: 0};
    applyStimulus(vC, 1, "after abort");

    // Asynchronous reset in the middle of a period with ERR set
    doSet(100);
    applyStimulus(vecs[3], 1, "pre reset");
    runCycles(30, 100, 19);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("async reset duty", 32'(DUTY), 0);
    checkOutput("async reset phase", 32'(PHASE), 0);
    checkOutput("async reset valid", 32'(VALID), 0);
    checkOutput("async reset err", 32'(ERR), 0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // Period of one clock stays IDLE
    doSet(1);
    valids = 0;
    for (int i = 0; i < 300; i++) begin
      PWM_IN = ((i % 7) < 3);
      @(posedge CLK);
      #1;
      if (VALID === 1'b1) valids++;
    end
    checkOutput("cycle1 valid count", valids, 0);
    checkOutput("cycle1 duty", 32'(DUTY), 0);
    checkOutput("cycle1 err", 32'(ERR), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 13: bit width of CYCLE, DUTY and PHASE.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock, with all logic rising-edge triggered.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port SET, input, 1 bit: loads CYCLE when high.
REQ-005 SHALL have port CYCLE, input, WIDTH bits: PWM period in clocks.
REQ-006 SHALL have port PWM_IN, input, 1 bit: PWM waveform under measurement, synchronous to CLK.
REQ-007 SHALL have port DUTY, output, WIDTH bits: measured high-time in clocks.
REQ-008 SHALL have port PHASE, output, WIDTH bits: measured rising-edge position in clocks.
REQ-009 SHALL have port VALID, output, 1 bit: one-clock strobe marking a new DUTY/PHASE result.
REQ-010 SHALL have port ERR, output, 1 bit: sticky glitch flag.

Function
REQ-011 SHALL latch CYCLE into an internal period register on the clock where SET=1.
- Period counter t restarts at 0 on the following clock.
- t increments each clock and wraps from period-1 to 0.
REQ-012 SHALL implement states IDLE, ARM, MEAS.
- Reset -> IDLE.
- SET with CYCLE>=2 -> ARM; SET with CYCLE<2 -> IDLE.
- ARM -> MEAS when t==0.
- MEAS stays MEAS across period wraps.
REQ-013 SHALL in MEAS count the clocks with PWM_IN=1 (high_cnt), saturating at period.
REQ-014 SHALL in MEAS detect a rising edge when the registered previous PWM_IN is 0 and the current PWM_IN is 1, recording t of the first rising edge as rise_t.
- The previous-sample register is kept across period wraps.
REQ-015 SHALL, on the clock after the sample at t==period-1 in MEAS:
- load DUTY=high_cnt;
- load PHASE=rise_t, or 0 if no rise occurred;
- pulse VALID=1 for exactly one clock;
- clear high_cnt and the rise record for the next period.
REQ-016 SHALL produce DUTY=period, PHASE=0 for constant-high input, and DUTY=0, PHASE=0 for constant-low input.
REQ-017 SHALL set ERR when a second rising edge occurs within one period.
- ERR stays set until RST or SET.
- The result of that period is still published.
REQ-018 SHALL, on SET during MEAS or ARM, abort the current period with no VALID, keep DUTY/PHASE unchanged, and re-arm per REQ-011/012.
REQ-019 SHALL give SET priority over a simultaneous period-end publish, so that no VALID is issued on that clock.

Reset
REQ-020 SHALL on RST=1 asynchronously force DUTY=0, PHASE=0, VALID=0, ERR=0, period=0, t=0, high_cnt=0, state=IDLE.
REQ-021 SHALL issue no VALID before one complete period has been measured after reset or SET.

Configuration
REQ-022 SHALL report PHASE as (period - rise_t) mod period when PWM_CAPTURE_PHASE_INV_EN is defined, matching an inverted-phase generator; without the macro, PHASE SHALL equal rise_t.

Structure
REQ-023 SHALL place the WIDTH default constant and the state enum type (IDLE/ARM/MEAS) in shared package pwm_pkg.
REQ-024 SHALL implement the period register, t counter and wrap flag in sub-module pwm_period_counter, instantiated once.

Verification
REQ-025 SHALL cover: SET CYCLE=5000, PWM high for t in [0,2499] -> VALID every 5000 clocks with DUTY=2500, PHASE=0.
REQ-026 SHALL cover: CYCLE=5000, PWM high for t in [1000,1799] -> DUTY=800, PHASE=1000; with PWM_CAPTURE_PHASE_INV_EN defined, PHASE=4000.
REQ-027 SHALL cover: CYCLE=100, PWM constant 1 -> DUTY=100, PHASE=0; PWM constant 0 -> DUTY=0, PHASE=0; ERR=0 throughout.
REQ-028 SHALL cover: CYCLE=100, PWM high for t in [10,19] and t in [40,44] -> ERR=1, DUTY=15, PHASE=10, and ERR cleared by the next SET.
REQ-029 SHALL cover: SET CYCLE=200 at t=50 of a CYCLE=100 measurement -> no VALID for 200 clocks, first VALID about 201 clocks after SET, previous DUTY held.
REQ-030 SHALL cover: RST asserted mid-period -> all outputs 0 immediately (asynchronous), and SET CYCLE=1 -> stays IDLE, no VALID.
